// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, instr, misaligned} between the PC stage and decode.
// Status outputs come from registered state only; the head entry is read combinationally from storage.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Flush,
    input  logic                     In_Valid,
    input  logic [31:0]              In_Pc,
    input  logic [31:0]              In_Instr,
    output logic                     In_Ready,
    output logic                     Out_Valid,
    output logic [31:0]              Out_Pc,
    output logic [31:0]              Out_Instr,
    output logic                     Out_Misaligned,
    input  logic                     Out_Ready,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [AW:0]     C_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]     C_EMPTY   = {(AW+1){1'b0}};
    localparam logic [AW:0]     C_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]   C_PTR_ONE = AW'(1);
    localparam logic [31:0]     C_NOP     = 32'h0000_0013;

    logic [31:0]      r_pc_mem    [DEPTH];
    logic [31:0]      r_instr_mem [DEPTH];
    logic [DEPTH-1:0] r_mis_mem;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_push_store;

    assign In_Ready     = (r_count != C_FULL);
    assign Out_Valid    = (r_count != C_EMPTY);
    assign Count        = r_count;
    assign w_push       = In_Valid & In_Ready;
    assign w_pop        = Out_Valid & Out_Ready;
    assign w_push_store = w_push & ~Flush;

    // Occupancy update for push/pop combinations.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + C_CNT_ONE;
            2'b01:   w_count_nxt = r_count - C_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers and count; a redirect flush outranks any concurrent push or pop.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= C_EMPTY;
        end else if (Flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= C_EMPTY;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            r_count <= w_count_nxt;
        end
    end

    // Entry storage; contents are never cleared, only overwritten by accepted pushes.
    always_ff @(posedge Clk) begin
        if (w_push_store) begin
            r_pc_mem[r_wr_ptr]    <= In_Pc;
            r_instr_mem[r_wr_ptr] <= In_Instr;
            r_mis_mem[r_wr_ptr]   <= |In_Pc[1:0];
        end
    end

    // Head entry, or a NOP bubble when empty.
    always_comb begin
        Out_Pc         = 32'h0000_0000;
        Out_Instr      = C_NOP;
        Out_Misaligned = 1'b0;
        if (Out_Valid) begin
            Out_Pc         = r_pc_mem[r_rd_ptr];
            Out_Instr      = r_instr_mem[r_rd_ptr];
            Out_Misaligned = r_mis_mem[r_rd_ptr];
        end else begin
            Out_Pc         = 32'h0000_0000;
            Out_Instr      = C_NOP;
            Out_Misaligned = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table plus hand sequences, with a queue-based reference model
// that predicts every status and head output after each clock edge.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Reset, Flush, In_Valid, Out_Ready;
    logic [31:0] In_Pc, In_Instr;
    logic        In_Ready, Out_Valid, Out_Misaligned;
    logic [31:0] Out_Pc, Out_Instr;
    logic [2:0]  Count;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush), .In_Valid(In_Valid),
        .In_Pc(In_Pc), .In_Instr(In_Instr), .In_Ready(In_Ready),
        .Out_Valid(Out_Valid), .Out_Pc(Out_Pc), .Out_Instr(Out_Instr),
        .Out_Misaligned(Out_Misaligned), .Out_Ready(Out_Ready), .Count(Count)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        fl, iv;
        logic [31:0] pc;
        logic        ordy;
        logic [2:0]  e_cnt;
        logic        e_ir, e_ov;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic fl, logic iv, logic [31:0] pc, logic ordy,
                                logic [2:0] e_cnt, logic e_ir, logic e_ov,
                                logic [31:0] e_pc, logic e_mis);
        vec_t v;
        v.fl = fl; v.iv = iv; v.pc = pc; v.ordy = ordy;
        v.e_cnt = e_cnt; v.e_ir = e_ir; v.e_ov = e_ov; v.e_pc = e_pc; v.e_mis = e_mis;
        return v;
    endfunction

    function automatic logic [31:0] instr_of(logic [31:0] pc);
        return pc ^ 32'h1357_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model(input string tag);
        logic [31:0] e_pc, e_instr;
        logic        e_mis;
        int          n;
        n = sb.size();
        if (n > 0) begin
            e_pc = sb[0][63:32]; e_instr = sb[0][31:0]; e_mis = |e_pc[1:0];
        end else begin
            e_pc = 32'h0; e_instr = NOP; e_mis = 1'b0;
        end
        chk({tag, " Count"},     32'(Count),         32'(n));
        chk({tag, " In_Ready"},  32'(In_Ready),      32'(n != DEPTH));
        chk({tag, " Out_Valid"}, 32'(Out_Valid),     32'(n != 0));
        chk({tag, " Out_Pc"},    Out_Pc,             e_pc);
        chk({tag, " Out_Instr"}, Out_Instr,          e_instr);
        chk({tag, " Out_Mis"},   32'(Out_Misaligned), 32'(e_mis));
    endtask

    task automatic tick(input logic fl, input logic iv, input logic [31:0] pc,
                        input logic [31:0] instr, input logic ordy);
        logic do_push, do_pop;
        Flush = fl; In_Valid = iv; In_Pc = pc; In_Instr = instr; Out_Ready = ordy;
        do_push = iv && (sb.size() != DEPTH);
        do_pop  = (sb.size() != 0) && ordy;
        @(posedge Clk); #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (do_pop)  void'(sb.pop_front());
            if (do_push) sb.push_back({pc, instr});
        end
        compare_model("sb");
    endtask

    initial begin
        Reset = 1'b1; Flush = 1'b0; In_Valid = 1'b1; In_Pc = 32'h50; In_Instr = 32'h1;
        Out_Ready = 1'b1;
        #1;
        chk("rst Count", 32'(Count), 32'd0);
        chk("rst In_Ready", 32'(In_Ready), 32'd1);
        chk("rst Out_Valid", 32'(Out_Valid), 32'd0);
        chk("rst Out_Instr", Out_Instr, NOP);
        chk("rst Out_Pc", Out_Pc, 32'h0);
        @(posedge Clk); #1;
        chk("rst held Count", 32'(Count), 32'd0);
        chk("rst held Out_Valid", 32'(Out_Valid), 32'd0);
        Reset = 1'b0; In_Valid = 1'b0;

        // fill to full, ignored pushes, drain, underflow, misalignment
        tbl.push_back(mk(0, 1, 32'h0,   0, 3'd1, 1, 1, 32'h0,   0));
        tbl.push_back(mk(0, 1, 32'h4,   0, 3'd2, 1, 1, 32'h0,   0));
        tbl.push_back(mk(0, 1, 32'h8,   0, 3'd3, 1, 1, 32'h0,   0));
        tbl.push_back(mk(0, 1, 32'hC,   0, 3'd4, 0, 1, 32'h0,   0));
        tbl.push_back(mk(0, 1, 32'h10,  0, 3'd4, 0, 1, 32'h0,   0));
        tbl.push_back(mk(0, 1, 32'h14,  1, 3'd3, 1, 1, 32'h4,   0));
        tbl.push_back(mk(0, 0, 32'h0,   1, 3'd2, 1, 1, 32'h8,   0));
        tbl.push_back(mk(0, 0, 32'h0,   1, 3'd1, 1, 1, 32'hC,   0));
        tbl.push_back(mk(0, 0, 32'h0,   1, 3'd0, 1, 0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 32'h0,   1, 3'd0, 1, 0, 32'h0,   0));
        tbl.push_back(mk(0, 1, 32'h102, 0, 3'd1, 1, 1, 32'h102, 1));
        tbl.push_back(mk(0, 1, 32'h104, 1, 3'd1, 1, 1, 32'h104, 0));
        tbl.push_back(mk(0, 0, 32'h0,   1, 3'd0, 1, 0, 32'h0,   0));
        foreach (tbl[i]) begin
            tick(tbl[i].fl, tbl[i].iv, tbl[i].pc, instr_of(tbl[i].pc), tbl[i].ordy);
            chk($sformatf("vec%0d Count", i), 32'(Count), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d In_Ready", i), 32'(In_Ready), 32'(tbl[i].e_ir));
            chk($sformatf("vec%0d Out_Valid", i), 32'(Out_Valid), 32'(tbl[i].e_ov));
            chk($sformatf("vec%0d Out_Pc", i), Out_Pc, tbl[i].e_pc);
            chk($sformatf("vec%0d Out_Mis", i), 32'(Out_Misaligned), 32'(tbl[i].e_mis));
        end

        // push into empty: no bypass, visible one cycle later
        In_Valid = 1'b1; In_Pc = 32'h100; In_Instr = 32'h0050_0093; Out_Ready = 1'b1;
        #1;
        chk("nobypass Out_Valid", 32'(Out_Valid), 32'd0);
        chk("nobypass Out_Instr", Out_Instr, NOP);
        tick(0, 1, 32'h100, 32'h0050_0093, 1);
        chk("latency Out_Valid", 32'(Out_Valid), 32'd1);
        chk("latency Out_Pc", Out_Pc, 32'h100);
        chk("latency Out_Instr", Out_Instr, 32'h0050_0093);
        tick(0, 0, 32'h0, 32'h0, 1);

        // steady-state push+pop across several pointer wraps
        tick(0, 1, 32'h200, instr_of(32'h200), 0);
        tick(0, 1, 32'h204, instr_of(32'h204), 0);
        for (int i = 0; i < 10; i++) begin
            tick(0, 1, 32'(i * 4), instr_of(32'(i * 4)), 1);
            chk($sformatf("stream%0d Count", i), 32'(Count), 32'd2);
        end
        tick(0, 0, 32'h0, 32'h0, 1);
        tick(0, 0, 32'h0, 32'h0, 1);

        // flush beats concurrent push and pop
        for (int i = 0; i < 3; i++) tick(0, 1, 32'(32'h280 + i * 4), instr_of(32'(32'h280 + i * 4)), 0);
        tick(1, 1, 32'h300, instr_of(32'h300), 1);
        chk("flush Count", 32'(Count), 32'd0);
        chk("flush Out_Valid", 32'(Out_Valid), 32'd0);
        chk("flush In_Ready", 32'(In_Ready), 32'd1);
        tick(0, 0, 32'h0, 32'h0, 0);
        chk("flush entry absent", 32'(Out_Valid), 32'd0);

        // asynchronous reset pulse between edges
        for (int i = 0; i < 3; i++) tick(0, 1, 32'(32'h380 + i * 4), instr_of(32'(32'h380 + i * 4)), 0);
        In_Valid = 1'b0; Out_Ready = 1'b0;
        #2 Reset = 1'b1;
        #1;
        chk("arst Count", 32'(Count), 32'd0);
        chk("arst Out_Valid", 32'(Out_Valid), 32'd0);
        chk("arst In_Ready", 32'(In_Ready), 32'd1);
        chk("arst Out_Instr", Out_Instr, NOP);
        sb.delete();
        #1 Reset = 1'b0;
        tick(0, 1, 32'h400, instr_of(32'h400), 0);
        chk("post-rst Out_Valid", 32'(Out_Valid), 32'd1);
        chk("post-rst Out_Pc", Out_Pc, 32'h400);
        tick(0, 0, 32'h0, 32'h0, 1);

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            tick($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), rpc, $urandom,
                 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, meaning number of buffered fetch entries (power of two, >= 2).
REQ-002 SHALL provide port Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port Flush  input  1  synchronous discard of all queued entries (branch/jump redirect).
REQ-005 SHALL provide port In_Valid  input  1  fetch side presents an entry.
REQ-006 SHALL provide port In_Pc  input  32  fetch address of the entry.
REQ-007 SHALL provide port In_Instr  input  32  instruction word fetched at In_Pc.
REQ-008 SHALL provide port In_Ready  output  1  queue can accept an entry; drives the PC stage's PCWrite.
REQ-009 SHALL provide port Out_Valid  output  1  head entry available to decode.
REQ-010 SHALL provide port Out_Pc  output  32  head entry address.
REQ-011 SHALL provide port Out_Instr  output  32  head entry instruction.
REQ-012 SHALL provide port Out_Misaligned  output  1  head entry address has In_Pc[1:0] != 0.
REQ-013 SHALL provide port Out_Ready  input  1  decode accepts head entry this cycle.
REQ-014 SHALL provide port Count  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 SHALL store per entry {pc[31:0], instr[31:0], misaligned} in a circular buffer with write and read pointers wrapping modulo DEPTH.
REQ-016 SHALL push when In_Valid && In_Ready at a rising edge; misaligned bit captured as |In_Pc[1:0].
REQ-017 SHALL pop when Out_Valid && Out_Ready at a rising edge.
REQ-018 SHALL drive In_Ready = (Count != DEPTH) from registered state only; no combinational path from Out_Ready to In_Ready.
REQ-019 SHALL drive Out_Valid = (Count != 0) from registered state only.
REQ-020 SHALL present head entry on Out_Pc/Out_Instr/Out_Misaligned combinationally from storage when Out_Valid = 1.
REQ-021 SHALL drive Out_Pc = 0, Out_Instr = 32'h00000013 (NOP addi x0,x0,0), Out_Misaligned = 0 when Count = 0.
REQ-022 SHALL have push-to-output latency of one cycle; no bypass when empty (push into empty queue: Out_Valid rises next cycle).
REQ-023 SHALL keep Count unchanged on simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-024 SHALL ignore In_Valid when full (In_Ready = 0), even if a pop occurs the same cycle; no storage or pointer change for that entry.
REQ-025 SHALL ignore Out_Ready when empty; Count never underflows.
REQ-026 SHALL give Flush priority over push and pop: at the edge with Flush = 1, both pointers and Count go to 0 and any concurrent push or pop is discarded.
REQ-027 SHALL preserve strict FIFO order of entries across pointer wrap-around.
REQ-028 SHALL not alter stored entries except by push; storage contents need not be cleared.

Reset
REQ-029 SHALL on Reset = 1, immediately and independent of Clk, force read pointer, write pointer and Count to 0.
REQ-030 SHALL hold during reset: In_Ready = 1, Out_Valid = 0, Out_Pc = 0, Out_Instr = 32'h00000013, Out_Misaligned = 0.
REQ-031 SHALL abandon any in-flight push or pop when Reset asserts mid-cycle; first push accepted at the first rising edge after Reset deasserts.

Verification
REQ-032 SHALL pass: push pc 0x0/0x4/0x8/0xC with Out_Ready = 0, DEPTH = 4 -> Count = 4, In_Ready = 0; fifth push of 0x10 ignored; drain yields 0x0,0x4,0x8,0xC in order.
REQ-033 SHALL pass: empty queue, push 0x100/instr 0x00500093 with Out_Ready = 1 -> same cycle Out_Valid = 0, Out_Instr = 0x00000013; next cycle Out_Valid = 1, Out_Pc = 0x100.
REQ-034 SHALL pass: Count = 2, simultaneous push and pop for 10 cycles (pc 0x0..0x24) -> Count stays 2, outputs in order, pointers wrap at least twice.
REQ-035 SHALL pass: Count = 3, Flush = 1 with In_Valid = 1 and Out_Ready = 1 -> next cycle Count = 0, Out_Valid = 0, In_Ready = 1, flushed-cycle entry absent.
REQ-036 SHALL pass: push In_Pc = 0x102 -> on output Out_Misaligned = 1, Out_Pc = 0x102; following aligned entry shows Out_Misaligned = 0.
REQ-037 SHALL pass: Count = 3, Reset pulsed between clock edges -> Count = 0, Out_Valid = 0 before next edge; push after release appears normally.
